// File: rtl/ten_gig_rx_frame_buffer.sv
// Store-and-forward RX frame buffer for the 10G MAC user stream.
// Frames are released downstream only once fully received and checked.
module ten_gig_rx_frame_buffer #(
  parameter int P_MIN_LENGTH = 64,
  parameter int P_MAX_LENGTH = 9600,
  parameter int P_ADDR_WIDTH = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_s_axis_tvalid,
  input  logic [63:0] i_s_axis_tdata,
  input  logic [7:0]  i_s_axis_tkeep,
  input  logic        i_s_axis_tlast,
  input  logic        i_s_axis_tuser,
  output logic        o_m_axis_tvalid,
  input  logic        i_m_axis_tready,
  output logic [63:0] o_m_axis_tdata,
  output logic [7:0]  o_m_axis_tkeep,
  output logic        o_m_axis_tlast,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_drop_cnt,
  output logic        o_drop_pulse
);

  localparam int DEPTH = 1 << P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH:0] PTR_DEPTH = {1'b1, {P_ADDR_WIDTH{1'b0}}};
  localparam logic [P_ADDR_WIDTH:0] PTR_ONE   = {{P_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [15:0] MIN_LEN = 16'(P_MIN_LENGTH);
  localparam logic [15:0] MAX_LEN = 16'(P_MAX_LENGTH);

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_RECV,
    S_DROP
  } wr_state_t;

  wr_state_t state;

  logic [72:0] mem [DEPTH];

  logic [P_ADDR_WIDTH:0] wr_ptr;
  logic [P_ADDR_WIDTH:0] commit_ptr;
  logic [P_ADDR_WIDTH:0] rd_ptr;

  logic [15:0] len;
  logic [3:0]  beat_bytes;
  logic [16:0] len_sum;
  logic [15:0] len_next;
  logic        too_long;
  logic        len_ok;
  logic        buf_full;
  logic        in_frame;
  logic        mem_we;

  logic [72:0] pf_data;
  logic        pf_valid;
  logic        out_free;
  logic        rd_issue;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < 8; i++) begin
      beat_bytes = beat_bytes + 4'(i_s_axis_tkeep[i]);
    end
  end

  // Length of the frame including the current beat, saturating at 16 bits.
  always_comb begin
    if (state == S_IDLE) begin
      len_sum = 17'(beat_bytes);
    end else begin
      len_sum = {1'b0, len} + 17'(beat_bytes);
    end
    len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    too_long = (len_next > MAX_LEN);
    len_ok   = (len_next >= MIN_LEN) && !too_long;
  end

  // Full is judged on registered pointers only, so a same-cycle read cannot rescue a beat.
  assign buf_full = ((wr_ptr - rd_ptr) == PTR_DEPTH);
  assign in_frame = (state == S_IDLE) || (state == S_RECV);
  assign mem_we   = i_s_axis_tvalid && in_frame && !buf_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_SYNC;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      len          <= '0;
      o_good_cnt   <= '0;
      o_drop_cnt   <= '0;
      o_drop_pulse <= 1'b0;
    end else begin
      o_drop_pulse <= 1'b0;
      case (state)
        S_SYNC: begin
          if (!i_s_axis_tvalid || i_s_axis_tlast) begin
            state <= S_IDLE;
          end
        end
        S_IDLE, S_RECV: begin
          if (i_s_axis_tvalid) begin
            if (buf_full) begin
              wr_ptr       <= commit_ptr;
              o_drop_cnt   <= o_drop_cnt + 32'd1;
              o_drop_pulse <= 1'b1;
              state        <= i_s_axis_tlast ? S_IDLE : S_DROP;
            end else if (i_s_axis_tlast) begin
              if (!i_s_axis_tuser && len_ok) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                commit_ptr <= wr_ptr + PTR_ONE;
                o_good_cnt <= o_good_cnt + 32'd1;
              end else begin
                wr_ptr       <= commit_ptr;
                o_drop_cnt   <= o_drop_cnt + 32'd1;
                o_drop_pulse <= 1'b1;
              end
              state <= S_IDLE;
            end else if (too_long) begin
              wr_ptr       <= commit_ptr;
              o_drop_cnt   <= o_drop_cnt + 32'd1;
              o_drop_pulse <= 1'b1;
              state        <= S_DROP;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              len    <= len_next;
              state  <= S_RECV;
            end
          end
        end
        S_DROP: begin
          if (i_s_axis_tvalid && i_s_axis_tlast) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

  // A read is issued only into a prefetch slot that will be free after this edge.
  assign out_free = !o_m_axis_tvalid || i_m_axis_tready;
  assign rd_issue = (rd_ptr != commit_ptr) && (!pf_valid || out_free);

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[wr_ptr[P_ADDR_WIDTH-1:0]] <= {i_s_axis_tlast, i_s_axis_tkeep, i_s_axis_tdata};
    end
    if (rd_issue) begin
      pf_data <= mem[rd_ptr[P_ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr          <= '0;
      pf_valid        <= 1'b0;
      o_m_axis_tvalid <= 1'b0;
      o_m_axis_tdata  <= '0;
      o_m_axis_tkeep  <= '0;
      o_m_axis_tlast  <= 1'b0;
    end else begin
      if (out_free) begin
        o_m_axis_tvalid <= pf_valid;
        if (pf_valid) begin
          o_m_axis_tlast <= pf_data[72];
          o_m_axis_tkeep <= pf_data[71:64];
          o_m_axis_tdata <= pf_data[63:0];
        end
      end
      if (rd_issue) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        pf_valid <= 1'b1;
      end else if (out_free) begin
        pf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ten_gig_rx_frame_buffer.sv
// Scoreboard bench for ten_gig_rx_frame_buffer: good frames push expected beats,
// an independent monitor pops and compares every output handshake.
module tb_ten_gig_rx_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tuser;
  logic        o_tvalid;
  logic        m_tready;
  logic [63:0] o_tdata;
  logic [7:0]  o_tkeep;
  logic        o_tlast;
  logic [31:0] good_cnt;
  logic [31:0] drop_cnt;
  logic        drop_pulse;

  always #5 clk = ~clk;

  ten_gig_rx_frame_buffer dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tvalid (s_tvalid),
    .i_s_axis_tdata  (s_tdata),
    .i_s_axis_tkeep  (s_tkeep),
    .i_s_axis_tlast  (s_tlast),
    .i_s_axis_tuser  (s_tuser),
    .o_m_axis_tvalid (o_tvalid),
    .i_m_axis_tready (m_tready),
    .o_m_axis_tdata  (o_tdata),
    .o_m_axis_tkeep  (o_tkeep),
    .o_m_axis_tlast  (o_tlast),
    .o_good_cnt      (good_cnt),
    .o_drop_cnt      (drop_cnt),
    .o_drop_pulse    (drop_pulse)
  );

  logic [72:0] sb [$];
  int compared = 0;
  int mismatched = 0;
  int pulse_cycles = 0;
  logic prev_hold = 1'b0;
  logic [72:0] prev_beat;
  logic [72:0] exp_beat;

  task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] expv);
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stalled outputs stay put.
  always @(negedge clk) begin
    if (drop_pulse) pulse_cycles++;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold", 80'({o_tvalid, o_tlast, o_tkeep, o_tdata}), 80'({1'b1, prev_beat}));
      end
      if (o_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", 80'({1'b1, o_tlast, o_tkeep, o_tdata}), 80'(0));
        end else begin
          exp_beat = sb.pop_front();
          checkOutput("beat", 80'({o_tlast, o_tkeep, o_tdata}), 80'(exp_beat));
        end
      end
      prev_hold = o_tvalid && !m_tready;
      prev_beat = {o_tlast, o_tkeep, o_tdata};
    end
  end

  function automatic logic [63:0] beatData(input int id, input int i);
    return {8'(id), 24'(i), 32'hC0DE_0000 + 32'(i * 3)};
  endfunction

  function automatic logic [7:0] beatKeep(input int nbytes, input int i);
    int nbeats;
    int rem;
    nbeats = (nbytes + 7) / 8;
    if (i < nbeats - 1) return 8'hFF;
    rem = nbytes - 8 * (nbeats - 1);
    return 8'((1 << rem) - 1);
  endfunction

  task automatic driveBeat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    driveBeat(d, k, l, u);
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    goIdle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; returns #1 after the edge that captured its last beat.
  task automatic applyStimulus(input int id, input int nbytes, input logic bad, input logic expect_good);
    int nbeats;
    logic [63:0] d;
    logic [7:0] k;
    logic l;
    nbeats = (nbytes + 7) / 8;
    for (int i = 0; i < nbeats; i++) begin
      d = beatData(id, i);
      k = beatKeep(nbytes, i);
      l = (i == nbeats - 1);
      if (expect_good) sb.push_back({l, k, d});
      sendBeat(d, k, l, bad && l);
    end
    goIdle();
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({"drain_", name}, 80'(sb.size()), 80'(0));
    idleCycles(4);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", 80'(o_tvalid), 80'(0));
    checkOutput("reset_data", 80'({o_tlast, o_tkeep, o_tdata}), 80'(0));
    checkOutput("reset_cnts", 80'({good_cnt, drop_cnt, drop_pulse}), 80'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(2);

    // 64-byte good frame and its output latency
    applyStimulus(1, 64, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("latency_e0", 80'(o_tvalid), 80'(0));
    @(negedge clk);
    checkOutput("latency_e1", 80'(o_tvalid), 80'(0));
    @(negedge clk);
    checkOutput("latency_e2", 80'(o_tvalid), 80'(1));
    @(posedge clk);
    #1;
    waitDrain("t1", 100);
    checkOutput("good_cnt_t1", 80'(good_cnt), 80'(1));

    // 60-byte runt
    applyStimulus(2, 60, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_pulse_on", 80'(drop_pulse), 80'(1));
    @(negedge clk);
    checkOutput("drop_pulse_off", 80'(drop_pulse), 80'(0));
    @(posedge clk);
    #1;
    checkOutput("drop_cnt_t2", 80'(drop_cnt), 80'(1));
    idleCycles(4);

    // bad frame then good frame
    applyStimulus(3, 100, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(4, 64, 1'b0, 1'b1);
    waitDrain("t3", 100);
    checkOutput("cnts_t3", 80'({good_cnt, drop_cnt}), 80'({32'd2, 32'd2}));

    // 9608-byte frame, dropped on its last beat
    applyStimulus(5, 9608, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(6, 64, 1'b0, 1'b1);
    waitDrain("t4", 100);
    checkOutput("cnts_t4", 80'({good_cnt, drop_cnt}), 80'({32'd3, 32'd3}));

    // 9616-byte frame dropped early, then a maximum-length good frame
    applyStimulus(7, 9616, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(8, 9600, 1'b0, 1'b1);
    waitDrain("t4b", 2000);
    checkOutput("cnts_t4b", 80'({good_cnt, drop_cnt}), 80'({32'd4, 32'd4}));

    // fill with 2048 committed beats under backpressure, then overflow
    m_tready = 1'b0;
    for (int f = 0; f < 16; f++) begin
      applyStimulus(16 + f, 1024, 1'b0, 1'b1);
      idleCycles(1);
    end
    applyStimulus(40, 1500, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("cnts_t5", 80'({good_cnt, drop_cnt}), 80'({32'd20, 32'd5}));
    m_tready = 1'b1;
    waitDrain("t5", 5000);
    checkOutput("pulse_cycles", 80'(pulse_cycles), 80'(5));

    // reset mid-frame while a committed frame is stalled at the output
    m_tready = 1'b0;
    applyStimulus(60, 64, 1'b0, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 4; i++) begin
      sendBeat(beatData(61, i), 8'hFF, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    driveBeat(beatData(61, 4), 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    driveBeat(beatData(61, 5), 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_tvalid", 80'(o_tvalid), 80'(0));
    checkOutput("rst_mid_data", 80'({o_tlast, o_tkeep, o_tdata}), 80'(0));
    checkOutput("rst_mid_cnts", 80'({good_cnt, drop_cnt, drop_pulse}), 80'(0));
    @(posedge clk);
    #1;
    for (int i = 6; i < 13; i++) begin
      sendBeat(beatData(61, i), beatKeep(100, i), (i == 12), 1'b0);
    end
    idleCycles(3);
    m_tready = 1'b1;
    idleCycles(3);
    checkOutput("cnts_t6_sync", 80'({good_cnt, drop_cnt}), 80'(0));
    applyStimulus(62, 64, 1'b0, 1'b1);
    waitDrain("t6", 100);
    checkOutput("cnts_t6", 80'({good_cnt, drop_cnt}), 80'({32'd1, 32'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
